clock_datapath: RTL and testbench

//  Responder side of the clock/calendar control-word interface. The PLA controllers drive

---
 rtl/clock_datapath.sv | 91 +++++++++
 tb/tb_clock_datapath.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clock_datapath.sv
// Register-transfer datapath for the clock/calendar controller: shared bus, register file,
// ALU, key capture/counter and tick flag, driven by decoded control lines.
module clock_datapath #(
   parameter int W    = 6,
   parameter int NREG = 8,
   parameter int KMAX = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NREG)-1:0] addr,
   input  logic [W-1:0]            key_in,
   input  logic                    key_vld,
   input  logic                    tick,
   input  logic                    La,
   input  logic                    Lb,
   input  logic                    Ea,
   input  logic                    Er,
   input  logic                    Lr,
   input  logic                    Wr,
   input  logic [1:0]              s,
   input  logic                    Kc,
   input  logic                    Cc,
   input  logic                    Ts,
   output logic [W-1:0]            bus,
   output logic                    t,
   output logic                    k7,
   output logic                    c7,
   output logic                    Az,
   output logic                    err
);

   localparam int KW = $clog2(KMAX + 1);
   localparam logic [KW-1:0] KMAX_C = KW'(KMAX);

   logic [W-1:0]  a, b, r, key_r;
   logic [W-1:0]  rf [NREG];
   logic [KW-1:0] kcnt;
   logic [W:0]    alu;

   // Priority mux: R beats A so a contention cycle still has a defined bus value.
   always_comb begin
      bus = rf[addr];
      if (Er)      bus = r;
      else if (Ea) bus = a;
      else if (Kc) bus = key_r;
   end

   // Bit W carries the add carry or the subtract borrow.
   always_comb begin
      alu = '0;
      case (s)
         2'b00: alu = {1'b0, a} + {1'b0, b};
         2'b01: alu = {1'b0, a} - {1'b0, b};
         2'b10: alu = {1'b0, a} + (W+1)'(1);
         2'b11: alu = {1'b0, a};
         default: alu = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a     <= '0;
         b     <= '0;
         r     <= '0;
         c7    <= 1'b0;
         key_r <= '0;
         kcnt  <= '0;
         t     <= 1'b0;
         err   <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         if (La) a <= bus;
         if (Lb) b <= bus;
         if (Wr) rf[addr] <= bus;
         if (Lr) begin
            r  <= alu[W-1:0];
            c7 <= alu[W];
         end
         if (key_vld) key_r <= key_in;
         if (Cc)                       kcnt <= '0;
         else if (Kc && kcnt != KMAX_C) kcnt <= kcnt + 1'b1;
         // A tick arriving with its acknowledge must not be lost.
         t <= tick | (t & ~Ts);
         if (Ea && Er) err <= 1'b1;
      end
   end

   assign k7 = (kcnt == KMAX_C);
   assign Az = (a == '0);

endmodule

// File: tb/tb_clock_datapath.sv
// Directed-vector bench for clock_datapath; expected values are hand-computed constants.
module tb_clock_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] addr;
   logic [5:0] key_in;
   logic       key_vld, tick, La, Lb, Ea, Er, Lr, Wr, Kc, Cc, Ts;
   logic [1:0] s;
   logic [5:0] bus;
   logic       t, k7, c7, Az, err;

   int n_vec  = 0;
   int n_fail = 0;

   clock_datapath #(.W(6), .NREG(8), .KMAX(7)) dut (
      .clk(clk), .rst(rst), .addr(addr), .key_in(key_in), .key_vld(key_vld),
      .tick(tick), .La(La), .Lb(Lb), .Ea(Ea), .Er(Er), .Lr(Lr), .Wr(Wr), .s(s),
      .Kc(Kc), .Cc(Cc), .Ts(Ts), .bus(bus), .t(t), .k7(k7), .c7(c7), .Az(Az), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 2 time units after it.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Put v on the bus via the key register and load it into A (sel=0) or B (sel=1).
   task automatic ld(input bit sel, input logic [5:0] v);
      key_in = v; key_vld = 1'b1; cyc();
      key_vld = 1'b0; Kc = 1'b1; Cc = 1'b1;
      if (sel) Lb = 1'b1; else La = 1'b1;
      cyc();
      Kc = 1'b0; Cc = 1'b0; La = 1'b0; Lb = 1'b0;
   endtask

   task automatic read_r(input string tag, input logic [5:0] exp);
      Er = 1'b1; #1;
      chk(tag, bus, exp);
      Er = 1'b0; #1;
   endtask

   initial begin
      rst = 1'b1; addr = '0; key_in = '0; key_vld = 1'b0; tick = 1'b0;
      La = 0; Lb = 0; Ea = 0; Er = 0; Lr = 0; Wr = 0; s = 2'b00; Kc = 0; Cc = 0; Ts = 0;
      cyc(); cyc();
      chk("rst_bus", bus, 0);
      chk("rst_Az", Az, 1);
      chk("rst_k7", k7, 0);
      chk("rst_t", t, 0);
      chk("rst_c7", c7, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      cyc();

      // Key 59 onto bus, written into rf[0], then A from rf[0], B=1, add.
      key_in = 6'd59; key_vld = 1'b1; cyc(); key_vld = 1'b0;
      Kc = 1'b1; Wr = 1'b1; addr = 3'd0; #1;
      chk("key_on_bus", bus, 59);
      cyc(); Kc = 1'b0; Wr = 1'b0;
      chk("rf0_read", bus, 59);
      La = 1'b1; cyc(); La = 1'b0;
      chk("A59_Az", Az, 0);
      ld(1'b1, 6'd1);
      s = 2'b00; Lr = 1'b1; cyc(); Lr = 1'b0;
      read_r("add_R", 6'd60);
      chk("add_c7", c7, 0);
      ld(1'b0, 6'd63);
      s = 2'b10; Lr = 1'b1; cyc(); Lr = 1'b0;
      read_r("inc_wrap_R", 6'd0);
      chk("inc_wrap_c7", c7, 1);

      // Subtraction with and without borrow.
      ld(1'b0, 6'd3); ld(1'b1, 6'd5);
      s = 2'b01; Lr = 1'b1; cyc(); Lr = 1'b0;
      read_r("sub_borrow_R", 6'd62);
      chk("sub_borrow_c7", c7, 1);
      ld(1'b0, 6'd5); ld(1'b1, 6'd3);
      s = 2'b01; Lr = 1'b1; cyc(); Lr = 1'b0;
      read_r("sub_R", 6'd2);
      chk("sub_c7", c7, 0);

      // Lr and La together: R uses old A (5+1), A takes bus (key=3).
      s = 2'b10; Lr = 1'b1; La = 1'b1; Kc = 1'b1; Cc = 1'b1; cyc();
      Lr = 1'b0; La = 1'b0; Kc = 1'b0; Cc = 1'b0;
      read_r("lr_la_R", 6'd6);
      Ea = 1'b1; #1; chk("lr_la_A", bus, 3); Ea = 1'b0; #1;
      chk("c7_hold", c7, 0);

      // Key counter saturation and Cc priority.
      Cc = 1'b1; cyc(); Cc = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         Kc = 1'b1; cyc(); Kc = 1'b0;
         chk($sformatf("k7_after_%0d", i), k7, (i >= 7) ? 1 : 0);
      end
      Kc = 1'b1; Cc = 1'b1; cyc(); Kc = 1'b0; Cc = 1'b0;
      chk("kc_cc_k7", k7, 0);
      Kc = 1'b1; repeat (6) cyc();
      chk("k7_after_clear6", k7, 0);
      cyc(); Kc = 1'b0;
      chk("k7_after_clear7", k7, 1);

      // Tick flag.
      chk("t_idle", t, 0);
      tick = 1'b1; Ts = 1'b1; cyc(); tick = 1'b0;
      chk("tick_ts_same", t, 1);
      cyc(); Ts = 1'b0;
      chk("ts_clear", t, 0);
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
      chk("t_held", t, 1);

      // Bus contention: R wins, err sticky.
      ld(1'b0, 6'd9);
      s = 2'b11; Lr = 1'b1; cyc(); Lr = 1'b0;
      ld(1'b0, 6'd4);
      Ea = 1'b1; Er = 1'b1; #1;
      chk("contend_bus", bus, 9);
      chk("err_before_edge", err, 0);
      cyc(); Ea = 1'b0; Er = 1'b0;
      chk("err_set", err, 1);
      cyc(); cyc();
      chk("err_sticky", err, 1);

      // Reset mid-run with A=5, kcnt=4, t=1 and a write pending.
      ld(1'b0, 6'd5);
      Kc = 1'b1; repeat (4) cyc(); Kc = 1'b0;
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("pre_rst_t", t, 1);
      chk("pre_rst_Az", Az, 0);
      addr = 3'd2; key_in = 6'd17; key_vld = 1'b1; Kc = 1'b1; Wr = 1'b1; La = 1'b1;
      @(negedge clk); rst = 1'b1; #1;
      chk("mid_rst_Az", Az, 1);
      chk("mid_rst_k7", k7, 0);
      chk("mid_rst_t", t, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_c7", c7, 0);
      cyc();
      key_vld = 1'b0; Kc = 1'b0; Wr = 1'b0; La = 1'b0;
      rst = 1'b0; #1;
      chk("rst_rf2", bus, 0);
      read_r("rst_R", 6'd0);
      Kc = 1'b1; #1;
      chk("rst_key", bus, 0);
      Kc = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
